accel_in_wrapper: RTL and testbench

Input-side wrapper placed directly upstream of the series-accelerator controller/datapath.
- Accepts operand words x on a valid/ready stream and buffers them in a small FIFO.
- Issues one job at a time: presents x on acc_x, pulses acc_start for one cycle, then holds x stable until the accelerator raises done.
- Counts completed jobs, so software or a testbench can stream many operands without tracking accelerator timing.

---
 rtl/accel_in_wrapper.sv | 124 ++++++++++++
 tb/tb_accel_in_wrapper.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_in_wrapper.sv
// Input wrapper for the series accelerator: buffers operands in a FIFO and issues one job at a time.
// Latency: push to acc_start is 1 cycle; backpressure: in_ready drops only when the FIFO is full.

module accel_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_vld,
  input  logic [W-1:0]                 push_dat,
  input  logic                         pop_vld,
  output logic [W-1:0]                 pop_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Full/empty come from the occupancy count, so equal pointers are never ambiguous.
  assign full    = (count == CW'(DEPTH));
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
      if (push_vld && !pop_vld)      count <= count + CW'(1);
      else if (!push_vld && pop_vld) count <= count - CW'(1);
    end
  end
endmodule

module accel_in_wrapper #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_ready,
  output logic [DATA_W-1:0]            acc_x,
  output logic                         acc_start,
  input  logic                         acc_done,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic [CNT_W-1:0]             jobs_done
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t              state;
  logic                push_vld;
  logic                pop_vld;
  logic                full;
  logic [DATA_W-1:0]   pop_dat;

  // No full-bypass: a pop in the same cycle does not open the input.
  assign in_ready = !full;
  assign push_vld = in_valid && !full;
  assign pop_vld  = (state == S_IDLE) && (fifo_count != '0);

  accel_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push_vld),
    .push_dat (in_data),
    .pop_vld  (pop_vld),
    .pop_dat  (pop_dat),
    .count    (fifo_count),
    .full     (full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      acc_x     <= '0;
      acc_start <= 1'b0;
      busy      <= 1'b0;
      jobs_done <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop_vld) begin
            acc_x     <= pop_dat;
            acc_start <= 1'b1;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          acc_start <= 1'b0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          // Returning through IDLE gives the accelerator one cycle to settle before the next start.
          if (acc_done) begin
            jobs_done <= jobs_done + 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          acc_start <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_accel_in_wrapper.sv
// Bench for accel_in_wrapper: queue-based reference model checked every cycle plus literal spot checks.
module tb_accel_in_wrapper;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic [15:0] acc_x;
  logic        acc_start;
  logic        auto_done = 1'b0;
  logic        man_done = 1'b0;
  logic        acc_done;
  logic        busy;
  logic [2:0]  fifo_count;
  logic [7:0]  jobs_done;

  assign acc_done = auto_done | man_done;

  accel_in_wrapper #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .acc_x      (acc_x),
    .acc_start  (acc_start),
    .acc_done   (acc_done),
    .busy       (busy),
    .fifo_count (fifo_count),
    .jobs_done  (jobs_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference model: FIFO contents, the job in flight and how many edges it has been out.
  logic [15:0] q[$];
  logic [15:0] m_x = '0;
  bit          m_active = 1'b0;
  int          m_age = 0;
  int          m_jobs = 0;

  initial forever begin
    @(negedge rst);
    q.delete();
    m_x = '0;
    m_active = 1'b0;
    m_age = 0;
    m_jobs = 0;
  end

  initial forever begin
    @(posedge clk);
    if (rst) begin
      bit do_push;
      do_push = in_valid && (q.size() < DEPTH);
      if (m_active) begin
        if (m_age >= 1 && acc_done) begin
          m_active = 1'b0;
          m_jobs = (m_jobs + 1) % 256;
        end else begin
          m_age++;
        end
      end else if (q.size() > 0) begin
        m_x = q.pop_front();
        m_active = 1'b1;
        m_age = 0;
      end
      if (do_push) q.push_back(in_data);
    end
  end

  bit          cmp_en = 1'b0;
  logic [15:0] dut_log[$];

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("in_ready",   in_ready,   (q.size() < DEPTH));
      chk("fifo_count", fifo_count, q.size());
      chk("acc_start",  acc_start,  (m_active && m_age == 0));
      chk("busy",       busy,       m_active);
      chk("acc_x",      acc_x,      m_x);
      chk("jobs_done",  jobs_done,  m_jobs);
      if (acc_start) dut_log.push_back(acc_x);
    end
  end

  // Accelerator stand-in: answers each start with a done pulse after a delay.
  bit auto_en = 1'b0;
  bit rand_dly = 1'b0;
  int dly = 5;
  int cnt = 0;

  initial forever begin
    @(negedge clk);
    auto_done = 1'b0;
    if (!rst) begin
      cnt = 0;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) auto_done = 1'b1;
      end
      if (acc_start && auto_en) cnt = rand_dly ? int'($urandom_range(1, 6)) : dly;
    end
  end

  task automatic push(input logic [15:0] d);
    int n;
    in_valid = 1'b1;
    in_data = d;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout_fail("push_accept");
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((m_active || q.size() > 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) timeout_fail("wait_idle");
    @(negedge clk);
  endtask

  task automatic do_reset(input int cyc);
    in_valid = 1'b0;
    man_done = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (cyc) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    dut_log.delete();
  endtask

  task automatic check_log(input string name, input logic [15:0] exp[$]);
    chk({name, "_len"}, dut_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < dut_log.size(); i++)
      chk(name, dut_log[i], exp[i]);
  endtask

  initial begin
    logic [15:0] sent[$];
    #1 rst = 1'b0;
    cmp_en = 1'b1;

    // Reset then idle
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_acc_start", acc_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_jobs", jobs_done, 0);
    chk("rst_acc_x", acc_x, 0);

    // Single job
    auto_en = 1'b1;
    rand_dly = 1'b0;
    dly = 5;
    push(16'h0100);
    chk("single_cnt_after_push", fifo_count, 1);
    chk("single_no_start_yet", acc_start, 0);
    @(negedge clk);
    chk("single_start", acc_start, 1);
    chk("single_acc_x", acc_x, 16'h0100);
    @(negedge clk);
    chk("single_start_gone", acc_start, 0);
    chk("single_busy", busy, 1);
    wait_idle(100);
    chk("single_busy_end", busy, 0);
    chk("single_jobs", jobs_done, 1);

    // Fill to full
    do_reset(2);
    dly = 20;
    for (int i = 1; i <= 5; i++) push(16'(i));
    chk("full_count", fifo_count, 4);
    chk("full_in_ready", in_ready, 0);
    chk("full_jobs_before", jobs_done, 0);
    push(16'h0006);
    chk("full_first_done", jobs_done, 1);
    wait_idle(400);
    sent.delete();
    for (int i = 1; i <= 6; i++) sent.push_back(16'(i));
    check_log("full_order", sent);
    chk("full_jobs", jobs_done, 6);

    // Pointer wrap with random gaps and random accelerator delays
    do_reset(2);
    rand_dly = 1'b1;
    sent.delete();
    for (int i = 0; i < 10; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      sent.push_back(d);
      push(d);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle(1000);
    check_log("wrap_order", sent);
    chk("wrap_jobs", jobs_done, 10);

    // Spurious done in IDLE and in ISSUE
    do_reset(2);
    auto_en = 1'b0;
    rand_dly = 1'b0;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    @(negedge clk);
    chk("spur_idle_jobs", jobs_done, 0);
    chk("spur_idle_busy", busy, 0);
    push(16'h0055);
    @(negedge clk);
    chk("spur_issue_start", acc_start, 1);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    chk("spur_issue_jobs", jobs_done, 0);
    chk("spur_issue_busy", busy, 1);
    repeat (2) @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    chk("spur_real_done", jobs_done, 1);
    chk("spur_real_busy", busy, 0);

    // Reset mid-job
    do_reset(2);
    auto_en = 1'b1;
    dly = 30;
    push(16'h0011);
    push(16'h0022);
    push(16'h0033);
    repeat (2) @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_count", fifo_count, 2);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_acc_x", acc_x, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    @(negedge clk);
    chk("mid_late_done_jobs", jobs_done, 0);
    chk("mid_late_done_busy", busy, 0);
    dly = 3;
    dut_log.delete();
    push(16'h00AA);
    wait_idle(100);
    sent.delete();
    sent.push_back(16'h00AA);
    check_log("mid_new_job", sent);
    chk("mid_new_jobs", jobs_done, 1);

    // Counter wrap after 256 jobs
    do_reset(2);
    dly = 1;
    for (int i = 0; i < 256; i++) push(16'($urandom));
    wait_idle(2000);
    chk("wrap256_len", dut_log.size(), 256);
    chk("wrap256_jobs", jobs_done, 0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end
endmodule
